exe_wb_arbiter: RTL
===================

// Module: exe_wb_arbiter
// PURPOSE
//  Parametrised writeback arbiter for the execution stage. It collects results from NUM_CH
//  functional-unit channels (integer, mem, mul/div, csr, ...) over valid/ready handshakes.
//  It grants one channel per cycle, round-robin, and registers the winner into the writeback stage.
//  It drives the register-file write port, the exe bypass bus and exception reporting.
//  After a reported exception it drains and discards results until the pipeline flush.
// PARAMETERS
//  NUM_CH   4   number of result channels (>=1)
//  DATA_W   64  result data width
//  ADDR_W   40  PC width
//  CAUSE_W  64  exception cause width
// PORTS
//  clk_i            in   1               clock
//  rstn_i           in   1               asynchronous active-low reset
//  flush_i          in   1               pipeline flush (kill/eret)
//  ch_valid_i       in   NUM_CH          channel i holds a result
//  ch_ready_o       out  NUM_CH          channel i result consumed this cycle
//  ch_pc_i          in   NUM_CH*ADDR_W   PC per channel, channel i at [i*ADDR_W +: ADDR_W]
//  ch_we_i          in   NUM_CH          result writes the register file
//  ch_rd_i          in   NUM_CH*5        destination register
//  ch_data_i        in   NUM_CH*DATA_W   result data
//  ch_xcpt_i        in   NUM_CH          result carries an exception
//  ch_xcpt_cause_i  in   NUM_CH*CAUSE_W  exception cause
//  wb_valid_o       out  1               registered result valid
//  wb_pc_o          out  ADDR_W          registered PC
//  wb_we_o          out  1               register-file write enable
//  wb_addr_o        out  5               register-file write address
//  wb_data_o        out  DATA_W          register-file write data
//  wb_xcpt_o        out  1               exception reported
//  wb_xcpt_cause_o  out  CAUSE_W         exception cause
//  bypass_we_o      out  1               bypass enable (= wb_we_o)
//  bypass_addr_o    out  5               bypass address (= wb_addr_o)
//  bypass_data_o    out  DATA_W          bypass data (= wb_data_o)
// BEHAVIOUR
//  - Reset (async, rstn_i low):
//    - all registered outputs 0; state RUN; rr pointer 0.
//    - ch_ready_o forced 0 while rstn_i is low.
//  - FSM states: RUN, DRAIN.
//  - RUN, grant:
//    - scan ch_valid_i starting at the pointer, wrapping modulo NUM_CH.
//    - the first valid channel is granted; ch_ready_o is one-hot or 0, combinational, same cycle.
//  - Pointer update:
//    - after granting channel g, pointer <= (g+1) mod NUM_CH.
//    - no grant leaves the pointer unchanged.
//    - with NUM_CH=1 the pointer stays 0.
//  - Output register, latency 1 cycle after the grant:
//    - wb_valid_o <= 1; pc, data and cause latched from the granted channel.
//    - wb_addr_o <= rd.
//    - wb_we_o <= we & (rd!=0) & ~xcpt.
//    - no grant: wb_valid_o, wb_we_o, wb_xcpt_o <= 0; other fields hold their value.
//  - Bypass outputs are wires from the output register; there is no extra latency.
//  - Exception on a granted result:
//    - wb_xcpt_o <= 1 and wb_xcpt_cause_o <= cause; wb_we_o <= 0.
//    - next state DRAIN.
//  - DRAIN:
//    - ch_ready_o = ch_valid_i; all results are accepted and discarded.
//    - wb_valid_o, wb_we_o, wb_xcpt_o stay 0.
//  - flush_i:
//    - has priority over everything in either state; no ch_ready_o is asserted in that cycle.
//    - next cycle: wb_valid_o, wb_we_o, wb_xcpt_o = 0; pointer = 0; state = RUN.
//  - Channels must hold valid and payload stable until ready is asserted.
//  - Handshake timing: a result pending in the flush cycle is granted the following cycle if it is still valid.
//  - Simultaneous xcpt and non-xcpt valids: pure round-robin. Exceptions get no priority and program order is not reordered here.
//  - Width rules:
//    - data and cause are passed through unmodified.
//    - rd==0 never produces a write, but still produces wb_valid_o.
// TESTING
//  1. From reset, ch1 valid, rd=5, data=0xDEAD, we=1
//     -> ch_ready_o=4'b0010 in the same cycle;
//     -> next cycle wb_valid_o=1, wb_addr_o=5, wb_data_o=0xDEAD, wb_we_o=1, bypass_* identical.
//  2. From reset, ch0..3 all held valid
//     -> grants 0,1,2,3 on consecutive cycles;
//     -> then only ch0 and ch2 valid -> grant 0 then 2.
//  3. ch3 valid, we=1, rd=0, data=0x1
//     -> wb_valid_o=1, wb_we_o=0, bypass_we_o=0.
//  4. ch2 valid, xcpt=1, cause=5
//     -> wb_xcpt_o=1, wb_xcpt_cause_o=5, wb_we_o=0;
//     -> then ch0 and ch1 valid: both acked the next cycle, wb_valid_o=0;
//     -> after flush_i the next grant starts from ch0.
//  5. flush_i and ch3 valid in the same cycle
//     -> ch_ready_o=0; next cycle ch3 granted, wb_valid_o=1 one cycle later.
//  6. rstn_i pulled low while wb_valid_o=1 and wb_we_o=1
//     -> all outputs 0 immediately;
//     -> after release the first grant comes from ch0.

Source files
------------

// File: rtl/exe_wb_arbiter.sv
// Writeback arbiter: round-robin grant of one of NUM_CH result channels into a registered writeback/bypass stage.
// Latency: grant (ch_ready_o) is combinational in the request cycle; the winning result appears on wb_* one cycle later.
// Backpressure: a channel holds valid/payload until its ready; after an exception all results are drained until flush_i.
// Ports: clk_i/rstn_i/flush_i control; ch_* per-channel packed result buses with valid/ready;
//        wb_* registered writeback result and exception; bypass_* mirror the wb register-file write fields.
module exe_wb_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 40,
    parameter int CAUSE_W = 64
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        flush_i,
    input  logic [NUM_CH-1:0]           ch_valid_i,
    output logic [NUM_CH-1:0]           ch_ready_o,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_pc_i,
    input  logic [NUM_CH-1:0]           ch_we_i,
    input  logic [NUM_CH*5-1:0]         ch_rd_i,
    input  logic [NUM_CH*DATA_W-1:0]    ch_data_i,
    input  logic [NUM_CH-1:0]           ch_xcpt_i,
    input  logic [NUM_CH*CAUSE_W-1:0]   ch_xcpt_cause_i,
    output logic                        wb_valid_o,
    output logic [ADDR_W-1:0]           wb_pc_o,
    output logic                        wb_we_o,
    output logic [4:0]                  wb_addr_o,
    output logic [DATA_W-1:0]           wb_data_o,
    output logic                        wb_xcpt_o,
    output logic [CAUSE_W-1:0]          wb_xcpt_cause_o,
    output logic                        bypass_we_o,
    output logic [4:0]                  bypass_addr_o,
    output logic [DATA_W-1:0]           bypass_data_o
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              state;
    logic [PTR_W-1:0]    ptr;

    logic                gnt_vld;
    logic [NUM_CH-1:0]   gnt_onehot;
    logic [PTR_W-1:0]    ptr_nxt;
    logic [ADDR_W-1:0]   sel_pc;
    logic                sel_we;
    logic [4:0]          sel_rd;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_xcpt;
    logic [CAUSE_W-1:0]  sel_cause;

    // Rotating scan starting at ptr; the first valid channel wins and its payload is muxed out.
    always_comb begin : rr_scan
        int idx;
        idx        = 0;
        gnt_vld    = 1'b0;
        gnt_onehot = '0;
        ptr_nxt    = ptr;
        sel_pc     = '0;
        sel_we     = 1'b0;
        sel_rd     = '0;
        sel_data   = '0;
        sel_xcpt   = 1'b0;
        sel_cause  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!gnt_vld && ch_valid_i[idx]) begin
                gnt_vld         = 1'b1;
                gnt_onehot[idx] = 1'b1;
                ptr_nxt         = (idx + 1 >= NUM_CH) ? '0 : PTR_W'(idx + 1);
                sel_pc          = ch_pc_i[idx*ADDR_W +: ADDR_W];
                sel_we          = ch_we_i[idx];
                sel_rd          = ch_rd_i[idx*5 +: 5];
                sel_data        = ch_data_i[idx*DATA_W +: DATA_W];
                sel_xcpt        = ch_xcpt_i[idx];
                sel_cause       = ch_xcpt_cause_i[idx*CAUSE_W +: CAUSE_W];
            end
        end
    end

    // Ready is gated by reset directly so no channel sees a handshake while the block is held in reset.
    always_comb begin
        ch_ready_o = '0;
        if (!rstn_i || flush_i) begin
            ch_ready_o = '0;
        end else if (state == ST_DRAIN) begin
            ch_ready_o = ch_valid_i;
        end else begin
            ch_ready_o = gnt_onehot;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= ST_RUN;
            ptr             <= '0;
            wb_valid_o      <= 1'b0;
            wb_pc_o         <= '0;
            wb_we_o         <= 1'b0;
            wb_addr_o       <= '0;
            wb_data_o       <= '0;
            wb_xcpt_o       <= 1'b0;
            wb_xcpt_cause_o <= '0;
        end else if (flush_i) begin
            state      <= ST_RUN;
            ptr        <= '0;
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_xcpt_o  <= 1'b0;
        end else if (state == ST_DRAIN) begin
            // Results are being discarded; nothing reaches writeback until the flush.
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_xcpt_o  <= 1'b0;
        end else if (gnt_vld) begin
            ptr             <= ptr_nxt;
            wb_valid_o      <= 1'b1;
            wb_pc_o         <= sel_pc;
            wb_addr_o       <= sel_rd;
            wb_data_o       <= sel_data;
            wb_xcpt_cause_o <= sel_cause;
            wb_xcpt_o       <= sel_xcpt;
            // x0 is hardwired and a faulting instruction must not commit its result.
            wb_we_o         <= sel_we & (sel_rd != 5'd0) & ~sel_xcpt;
            if (sel_xcpt) begin
                state <= ST_DRAIN;
            end
        end else begin
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_xcpt_o  <= 1'b0;
        end
    end

    assign bypass_we_o   = wb_we_o;
    assign bypass_addr_o = wb_addr_o;
    assign bypass_data_o = wb_data_o;

endmodule
